// File: rtl/bus_ram_target_if.sv
// bmain bus channel bundle: command, write beats, read beats and error handshake.
interface bus_ram_target_if;
    logic        cvalid;
    logic        cready;
    logic        cmd;
    logic [26:0] addr;
    logic        wvalid;
    logic        wready;
    logic        wlast;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        rvalid;
    logic        rready;
    logic        rlast;
    logic [31:0] rdata;
    logic        error;
    logic        eack;

    modport master (
        output cvalid, cmd, addr, wvalid, wlast, wdata, wmask, rready, eack,
        input  cready, wready, rvalid, rlast, rdata, error
    );

    modport slave (
        input  cvalid, cmd, addr, wvalid, wlast, wdata, wmask, rready, eack,
        output cready, wready, rvalid, rlast, rdata, error
    );
endinterface

// File: rtl/bus_ram_target.sv
// bmain bus responder: serves 4-word wrapping line bursts (critical word first)
// from an on-chip synchronous RAM and reports window/protocol errors.
module bus_ram_target #(
    parameter int unsigned ADDR_BITS = 12,
    parameter logic [26:0] BASE      = 27'h0
) (
    input  logic            clk_core,
    input  logic            reset_n,
    bus_ram_target_if.slave bus
);
    localparam int unsigned RAM_WORDS = 32'd1 << ADDR_BITS;

    localparam logic [3:0] ST_IDLE  = 4'b0001;
    localparam logic [3:0] ST_WRITE = 4'b0010;
    localparam logic [3:0] ST_READ  = 4'b0100;
    localparam logic [3:0] ST_ERROR = 4'b1000;

    // RAM index of word {line, word}; BASE is window-aligned so truncation is exact
    function automatic logic [ADDR_BITS-1:0] ram_index(input logic [24:0] line, input logic [1:0] word);
        logic [26:0] offset;
        offset = {line, word} - BASE;
        return offset[ADDR_BITS-1:0];
    endfunction

    // True when the word address falls inside the RAM window
    function automatic logic in_window(input logic [26:0] word_addr);
        logic [26:0] offset;
        offset = word_addr - BASE;
        return ((offset >> ADDR_BITS) == 27'd0);
    endfunction

    logic [3:0]           state_r;
    logic [3:0]           state_nx_s;
    logic [1:0]           cnt_r;
    logic [24:0]          line_r;
    logic [1:0]           off_r;
    logic                 in_range_r;
    logic                 viol_r;
    logic                 cready_r;
    logic                 wready_r;
    logic                 rvalid_r;
    logic                 rlast_r;
    logic                 error_r;
    logic [31:0]          rdata_r;
    logic [31:0]          mem [RAM_WORDS];

    logic                 cmd_acc_s;
    logic                 in_range_s;
    logic                 wr_beat_s;
    logic                 wr_last_s;
    logic                 rd_hs_s;
    logic                 rd_last_s;
    logic                 viol_beat_s;
    logic [1:0]           wr_word_s;
    logic [1:0]           rd_next_word_s;
    logic [ADDR_BITS-1:0] wr_idx_s;
    logic [ADDR_BITS-1:0] rd_idx_s;
    logic                 rd_load_s;

    assign cmd_acc_s      = (state_r == ST_IDLE) & cready_r & bus.cvalid;
    assign in_range_s     = in_window(bus.addr);
    assign wr_beat_s      = wready_r & bus.wvalid;
    assign wr_last_s      = wr_beat_s & (cnt_r == 2'd3);
    assign rd_hs_s        = rvalid_r & bus.rready;
    assign rd_last_s      = rd_hs_s & rlast_r;
    // wlast must be set on the fourth beat and only there
    assign viol_beat_s    = (cnt_r == 2'd3) ? ~bus.wlast : bus.wlast;
    assign wr_word_s      = off_r + cnt_r;
    assign rd_next_word_s = off_r + cnt_r + 2'd1;
    assign wr_idx_s       = ram_index(line_r, wr_word_s);

    assign bus.cready = cready_r;
    assign bus.wready = wready_r;
    assign bus.rvalid = rvalid_r;
    assign bus.rlast  = rlast_r;
    assign bus.rdata  = rdata_r;
    assign bus.error  = error_r;

    // Select the RAM read address: beat 0 on accept, next beat on each read handshake
    always_comb begin
        rd_load_s = 1'b0;
        rd_idx_s  = ram_index(line_r, rd_next_word_s);
        if (cmd_acc_s && bus.cmd && in_range_s) begin
            rd_load_s = 1'b1;
            rd_idx_s  = ram_index(bus.addr[26:2], bus.addr[1:0]);
        end else if (rd_hs_s && !rlast_r) begin
            rd_load_s = 1'b1;
        end else begin
            rd_load_s = 1'b0;
        end
    end

    // Burst sequencing
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_acc_s) begin
                    if (!bus.cmd) begin
                        state_nx_s = ST_WRITE;
                    end else if (in_range_s) begin
                        state_nx_s = ST_READ;
                    end else begin
                        state_nx_s = ST_ERROR;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (wr_last_s) begin
                    state_nx_s = (!in_range_r || viol_r || viol_beat_s) ? ST_ERROR : ST_IDLE;
                end else begin
                    state_nx_s = ST_WRITE;
                end
            end
            ST_READ: begin
                if (rd_last_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_READ;
                end
            end
            ST_ERROR: begin
                if (bus.eack) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_ERROR;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State, burst bookkeeping and registered handshake outputs
    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 2'd0;
            line_r     <= 25'd0;
            off_r      <= 2'd0;
            in_range_r <= 1'b0;
            viol_r     <= 1'b0;
            cready_r   <= 1'b0;
            wready_r   <= 1'b0;
            rvalid_r   <= 1'b0;
            rlast_r    <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            cready_r <= (state_nx_s == ST_IDLE);
            wready_r <= (state_nx_s == ST_WRITE);
            rvalid_r <= (state_nx_s == ST_READ);
            error_r  <= (state_nx_s == ST_ERROR);
            if (cmd_acc_s) begin
                line_r     <= bus.addr[26:2];
                off_r      <= bus.addr[1:0];
                in_range_r <= in_range_s;
                cnt_r      <= 2'd0;
                viol_r     <= 1'b0;
                rlast_r    <= 1'b0;
            end else if (wr_beat_s) begin
                cnt_r  <= cnt_r + 2'd1;
                viol_r <= viol_r | viol_beat_s;
            end else if (rd_hs_s) begin
                cnt_r   <= cnt_r + 2'd1;
                rlast_r <= (cnt_r == 2'd2);
            end
        end
    end

    // Byte-masked RAM write, suppressed for out-of-window bursts
    always_ff @(posedge clk_core) begin
        if (wr_beat_s && in_range_r) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wmask[b]) begin
                    mem[wr_idx_s][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end

    // Registered RAM read port; holds while the initiator stalls
    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            rdata_r <= 32'h0;
        end else if (rd_load_s) begin
            rdata_r <= mem[rd_idx_s];
        end
    end
endmodule

// File: tb/tb_bus_ram_target.sv
// Self-checking bench for bus_ram_target with a line-level memory model.
module tb_bus_ram_target;
    localparam int WORDS = 4096;

    logic clk_core = 1'b0;
    logic reset_n  = 1'b1;
    int   checks   = 0;
    int   errors   = 0;

    logic [31:0]  ref_mem [int];
    logic [127:0] got;
    logic [127:0] expv;
    logic [3:0]   lf;
    int           nb;
    int           unst;
    int           acc;
    bit           fv;
    bit           va;
    bit           ok;

    bus_ram_target_if bus ();

    bus_ram_target #(.ADDR_BITS(12), .BASE(27'h0)) dut (
        .clk_core (clk_core),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    always #5 clk_core = ~clk_core;

    // Word address of beat i of a burst starting at a (wraps within the line)
    function automatic int beat_addr(input logic [26:0] a, input int i);
        logic [1:0] w;
        w = 2'((int'(a[1:0]) + i) % 4);
        return int'({a[26:2], w});
    endfunction

    function automatic void model_write(input logic [26:0] a, input logic [127:0] d, input logic [15:0] m);
        logic [31:0] w;
        int idx;
        if (int'(a) < WORDS) begin
            for (int i = 0; i < 4; i++) begin
                idx = beat_addr(a, i);
                w = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (m[4*i+b]) w[8*b +: 8] = d[32*i + 8*b +: 8];
                ref_mem[idx] = w;
            end
        end
    endfunction

    function automatic logic [127:0] model_read(input logic [26:0] a);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[32*i +: 32] = ref_mem[beat_addr(a, i)];
        return r;
    endfunction

    function automatic bit line_known(input logic [26:0] a);
        bit k;
        k = 1'b1;
        for (int i = 0; i < 4; i++) if (!ref_mem.exists(beat_addr(a, i))) k = 1'b0;
        return k;
    endfunction

    task automatic issue_cmd(input logic c, input logic [26:0] a, output bit acc_ok);
        int n;
        @(negedge clk_core);
        bus.cvalid = 1'b1; bus.cmd = c; bus.addr = a;
        n = 0;
        while (bus.cready !== 1'b1 && n < 50) begin
            @(negedge clk_core);
            n++;
        end
        acc_ok = (bus.cready === 1'b1);
        @(negedge clk_core);
        bus.cvalid = 1'b0;
    endtask

    task automatic send_beats(input logic [127:0] d, input logic [15:0] m, input logic [3:0] lastpat);
        int n;
        acc = 0;
        for (int b = 0; b < 4; b++) begin
            bus.wvalid = 1'b1; bus.wdata = d[32*b +: 32]; bus.wmask = m[4*b +: 4]; bus.wlast = lastpat[b];
            n = 0;
            while (bus.wready !== 1'b1 && n < 20) begin
                @(negedge clk_core);
                n++;
            end
            if (bus.wready === 1'b1) acc++;
            @(negedge clk_core);
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
    endtask

    task automatic read_beats(input logic [7:0] rpat, input int patlen);
        logic [31:0] prev_d;
        logic        prev_l;
        bit          stalled;
        got = '0; lf = '0; nb = 0; unst = 0; stalled = 1'b0; prev_d = '0; prev_l = 1'b0;
        fv = (bus.rvalid === 1'b1);
        for (int cyc = 0; cyc < 64 && nb < 4; cyc++) begin
            bus.rready = rpat[cyc % patlen];
            if (stalled && (bus.rvalid !== 1'b1 || bus.rdata !== prev_d || bus.rlast !== prev_l))
                unst++;
            if (bus.rvalid === 1'b1 && bus.rready === 1'b1) begin
                got[32*nb +: 32] = bus.rdata;
                lf[nb] = bus.rlast;
                nb++;
                stalled = 1'b0;
            end else begin
                stalled = (bus.rvalid === 1'b1);
                prev_d = bus.rdata;
                prev_l = bus.rlast;
            end
            @(negedge clk_core);
        end
        bus.rready = 1'b0;
        va = bus.rvalid;
    endtask

    task automatic pulse_eack();
        bus.eack = 1'b1;
        @(negedge clk_core);
        bus.eack = 1'b0;
    endtask

    task automatic test_reset();
        bus.cvalid = 1'b0; bus.cmd = 1'b0; bus.addr = '0; bus.wvalid = 1'b0; bus.wlast = 1'b0;
        bus.wdata = '0; bus.wmask = '0; bus.rready = 1'b0; bus.eack = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk_core);
        checks++;
        if ({bus.cready, bus.wready, bus.rvalid, bus.rlast, bus.error, bus.rdata} !== 37'd0) begin
            errors++;
            $display("FAIL reset_outputs: got cready=%b wready=%b rvalid=%b rlast=%b error=%b rdata=%h, expected all 0",
                     bus.cready, bus.wready, bus.rvalid, bus.rlast, bus.error, bus.rdata);
        end
        reset_n = 1'b1;
        @(negedge clk_core);
        checks++;
        if (bus.cready !== 1'b1) begin
            errors++; $display("FAIL reset_release_cready: got %b expected 1", bus.cready);
        end
    endtask

    task automatic test_write_read();
        issue_cmd(1'b0, 27'h10, ok);
        send_beats({32'h44, 32'h33, 32'h22, 32'h11}, 16'hFFFF, 4'b1000);
        model_write(27'h10, {32'h44, 32'h33, 32'h22, 32'h11}, 16'hFFFF);
        checks++;
        if (!ok || acc != 4 || bus.wready !== 1'b0 || bus.error !== 1'b0) begin
            errors++; $display("FAIL wr_line: got ok=%0d beats=%0d wready=%b error=%b expected 1/4/0/0", ok, acc, bus.wready, bus.error);
        end
        issue_cmd(1'b1, 27'h10, ok);
        read_beats(8'hFF, 8);
        checks++;
        if (!fv) begin errors++; $display("FAIL rd_latency: rvalid got 0 expected 1 one cycle after accept"); end
        checks++;
        if (got !== {32'h44, 32'h33, 32'h22, 32'h11} || got !== model_read(27'h10)) begin
            errors++; $display("FAIL rd_line: got %h expected %h", got, model_read(27'h10));
        end
        checks++;
        if (lf !== 4'b1000 || va !== 1'b0) begin
            errors++; $display("FAIL rd_line_last: got rlast=%b rvalid_after=%b expected 1000/0", lf, va);
        end
    endtask

    task automatic test_wrap();
        issue_cmd(1'b1, 27'h12, ok);
        read_beats(8'hFF, 8);
        checks++;
        if (got !== {32'h22, 32'h11, 32'h44, 32'h33} || lf !== 4'b1000) begin
            errors++; $display("FAIL wrap_order: got %h rlast=%b expected %h rlast=1000", got, lf, {32'h22, 32'h11, 32'h44, 32'h33});
        end
    endtask

    task automatic test_byte_mask();
        logic [127:0] d;
        d = {$urandom, $urandom, $urandom, 32'h12345678};
        issue_cmd(1'b0, 27'h20, ok);
        send_beats(d, 16'hFFFF, 4'b1000);
        model_write(27'h20, d, 16'hFFFF);
        d = {$urandom, $urandom, $urandom, 32'hAABBCCDD};
        issue_cmd(1'b0, 27'h20, ok);
        send_beats(d, 16'h0005, 4'b1000);
        model_write(27'h20, d, 16'h0005);
        checks++;
        if (acc != 4 || bus.error !== 1'b0) begin
            errors++; $display("FAIL mask_write: got beats=%0d error=%b expected 4/0", acc, bus.error);
        end
        issue_cmd(1'b1, 27'h20, ok);
        read_beats(8'hFF, 8);
        checks++;
        if (got[31:0] !== 32'h12BB56DD || got !== model_read(27'h20)) begin
            errors++; $display("FAIL mask_read: got %h expected %h (word0 12bb56dd)", got, model_read(27'h20));
        end
    endtask

    task automatic test_backpressure();
        issue_cmd(1'b1, 27'h10, ok);
        read_beats(8'b0101_1001, 7);
        checks++;
        if (nb != 4 || got !== model_read(27'h10) || lf !== 4'b1000) begin
            errors++; $display("FAIL bp_data: got beats=%0d data=%h rlast=%b expected 4/%h/1000", nb, got, lf, model_read(27'h10));
        end
        checks++;
        if (unst != 0 || va !== 1'b0) begin
            errors++; $display("FAIL bp_stall: got unstable=%0d rvalid_after=%b expected 0/0", unst, va);
        end
    endtask

    task automatic test_error_read();
        int bad;
        logic [26:0] a;
        a = 27'($urandom) | 27'h1000;
        checks++;
        if (bus.error !== 1'b0) begin errors++; $display("FAIL err_rd_pre: error got %b expected 0", bus.error); end
        issue_cmd(1'b1, a, ok);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.error !== 1'b1 || bus.rvalid !== 1'b0 || bus.cready !== 1'b0) bad++;
            @(negedge clk_core);
        end
        checks++;
        if (!ok || bad != 0) begin
            errors++; $display("FAIL err_rd_hold: got accepted=%0d bad_cycles=%0d expected 1/0", ok, bad);
        end
        pulse_eack();
        checks++;
        if (bus.error !== 1'b0 || bus.cready !== 1'b1) begin
            errors++; $display("FAIL err_rd_ack: got error=%b cready=%b expected 0/1", bus.error, bus.cready);
        end
    endtask

    task automatic test_error_write();
        logic [127:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        issue_cmd(1'b0, 27'h30, ok);
        send_beats(d, 16'hFFFF, 4'b0010);
        model_write(27'h30, d, 16'hFFFF);
        checks++;
        if (acc != 4 || bus.error !== 1'b1 || bus.wready !== 1'b0) begin
            errors++; $display("FAIL err_wlast: got beats=%0d error=%b wready=%b expected 4/1/0", acc, bus.error, bus.wready);
        end
        pulse_eack();
        checks++;
        if (bus.error !== 1'b0) begin errors++; $display("FAIL err_wlast_ack: error got %b expected 0", bus.error); end
        d = {$urandom, $urandom, $urandom, $urandom};
        issue_cmd(1'b0, 27'h1030, ok);
        send_beats(d, 16'hFFFF, 4'b1000);
        checks++;
        if (acc != 4 || bus.error !== 1'b1) begin
            errors++; $display("FAIL err_wr_range: got beats=%0d error=%b expected 4/1", acc, bus.error);
        end
        pulse_eack();
        issue_cmd(1'b1, 27'h30, ok);
        read_beats(8'hFF, 8);
        checks++;
        if (got !== model_read(27'h30)) begin
            errors++; $display("FAIL err_wr_ram: got %h expected %h", got, model_read(27'h30));
        end
    endtask

    task automatic test_random();
        logic [26:0]  a;
        logic [127:0] d;
        logic [15:0]  m;
        for (int it = 0; it < 16; it++) begin
            a = {15'd0, 10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3))};
            d = {$urandom, $urandom, $urandom, $urandom};
            m = line_known(a) ? 16'($urandom) : 16'hFFFF;
            issue_cmd(1'b0, a, ok);
            send_beats(d, m, 4'b1000);
            model_write(a, d, m);
            checks++;
            if (acc != 4 || bus.error !== 1'b0 || bus.wready !== 1'b0) begin
                errors++; $display("FAIL rnd_write: it=%0d beats=%0d error=%b wready=%b expected 4/0/0", it, acc, bus.error, bus.wready);
            end
            a[1:0] = 2'($urandom_range(0, 3));
            issue_cmd(1'b1, a, ok);
            read_beats(8'($urandom) | 8'h01, 8);
            expv = model_read(a);
            checks++;
            if (got !== expv || lf !== 4'b1000 || unst != 0 || va !== 1'b0) begin
                errors++; $display("FAIL rnd_read: it=%0d addr=%h got %h rlast=%b unstable=%0d expected %h rlast=1000", it, a, got, lf, unst, expv);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [127:0] d;
        issue_cmd(1'b1, 27'h10, ok);
        bus.rready = 1'b1;
        @(negedge clk_core);
        bus.rready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.rvalid !== 1'b0 || bus.error !== 1'b0 || bus.cready !== 1'b0) begin
            errors++; $display("FAIL rst_mid: got rvalid=%b error=%b cready=%b expected 0/0/0", bus.rvalid, bus.error, bus.cready);
        end
        @(negedge clk_core);
        reset_n = 1'b1;
        #1;
        checks++;
        if (bus.cready !== 1'b0) begin errors++; $display("FAIL rst_release_early: cready got %b expected 0", bus.cready); end
        @(negedge clk_core);
        checks++;
        if (bus.cready !== 1'b1) begin errors++; $display("FAIL rst_release_cready: got %b expected 1", bus.cready); end
        d = {$urandom, $urandom, $urandom, $urandom};
        issue_cmd(1'b0, 27'h41, ok);
        send_beats(d, 16'hFFFF, 4'b1000);
        model_write(27'h41, d, 16'hFFFF);
        issue_cmd(1'b1, 27'h43, ok);
        read_beats(8'hFF, 8);
        checks++;
        if (got !== model_read(27'h43) || lf !== 4'b1000 || !fv) begin
            errors++; $display("FAIL rst_after_burst: got %h rlast=%b expected %h rlast=1000", got, lf, model_read(27'h43));
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wrap();
        test_byte_mask();
        test_backpressure();
        test_error_read();
        test_error_write();
        test_random();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
